// File: rtl/iafu_snooper_q.sv
// iafu_snooper_q: snoops AR/AW address handshakes on NUM_CH MC AXI channels and
// matches each accepted address against a GRP_SIZE-entry table of migrating pages.
// Each hit becomes one event in a multi-push FIFO drained via a valid/ready port.
//
// Ports:
//   afu_clk, afu_rst         clock, asynchronous active-high reset
//   snp_en                   capture enable for new handshakes
//   ar_/aw_valid/ready/addr  per-channel AXI address handshakes (64 bits per channel)
//   snp_page_addr/_vld       page table and per-entry valid
//   evt_valid/ready          event output handshake
//   evt_idx/pg_off/is_wr/ch  head event fields (zero when evt_valid is low)
//   fifo_cnt                 current FIFO occupancy
//   drop_cnt, ovf_sticky     saturating drop count and sticky overflow, cleared by ovf_clr
module iafu_snooper_q #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned GRP_SIZE   = 8,
  parameter int unsigned PG_SHIFT   = 12,
  parameter int unsigned LINE_SHIFT = 6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                       afu_clk,
  input  logic                                       afu_rst,
  input  logic                                       snp_en,
  input  logic [NUM_CH-1:0]                          ar_valid,
  input  logic [NUM_CH-1:0]                          ar_ready,
  input  logic [NUM_CH*64-1:0]                       ar_addr,
  input  logic [NUM_CH-1:0]                          aw_valid,
  input  logic [NUM_CH-1:0]                          aw_ready,
  input  logic [NUM_CH*64-1:0]                       aw_addr,
  input  logic [GRP_SIZE-1:0][63:0]                  snp_page_addr,
  input  logic [GRP_SIZE-1:0]                        snp_page_vld,
  output logic                                       evt_valid,
  input  logic                                       evt_ready,
  output logic [$clog2(GRP_SIZE)-1:0]                evt_idx,
  output logic [PG_SHIFT-LINE_SHIFT-1:0]             evt_pg_off,
  output logic                                       evt_is_wr,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] evt_ch,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_cnt,
  output logic [CNT_W-1:0]                           drop_cnt,
  output logic                                       ovf_sticky,
  input  logic                                       ovf_clr
);

  localparam int unsigned NSRC   = 2 * NUM_CH;
  localparam int unsigned IDX_W  = $clog2(GRP_SIZE);
  localparam int unsigned OFF_W  = PG_SHIFT - LINE_SHIFT;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;
  // Stage 1 keeps only addr[51:LINE_SHIFT]: page number plus line offset.
  localparam int unsigned PA_W   = 52 - LINE_SHIFT;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             wr;
    logic [CH_W-1:0]  ch;
  } evt_t;

  // Whole-bus parity keeps the ignored address bits from looking dangling.
  logic unused_addr;
  assign unused_addr = ^{ar_addr, aw_addr, snp_page_addr};

  // Stage 1: capture handshakes, sources ordered ch0 AR, ch0 AW, ch1 AR, ...
  logic [NSRC-1:0] fire_d, fire_q;
  logic [PA_W-1:0] addr_d [NSRC];
  logic [PA_W-1:0] addr_q [NSRC];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      fire_d[2*c]   = ar_valid[c] & ar_ready[c] & snp_en;
      fire_d[2*c+1] = aw_valid[c] & aw_ready[c] & snp_en;
      addr_d[2*c]   = ar_addr[64*c+LINE_SHIFT +: PA_W];
      addr_d[2*c+1] = aw_addr[64*c+LINE_SHIFT +: PA_W];
    end
  end

  // Stage 2: table match against the current table; lowest index wins.
  logic [NSRC-1:0] hit;
  evt_t            ent [NSRC];

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      hit[s]     = 1'b0;
      ent[s].idx = '0;
      ent[s].off = addr_q[s][OFF_W-1:0];
      ent[s].wr  = 1'(s % 2);
      ent[s].ch  = CH_W'(s / 2);
      // Descending scan so the last assignment is the lowest matching index.
      for (int e = GRP_SIZE - 1; e >= 0; e--) begin
        if (snp_page_vld[e] && (snp_page_addr[e][51:PG_SHIFT] == addr_q[s][PA_W-1:OFF_W])) begin
          hit[s]     = fire_q[s];
          ent[s].idx = IDX_W'(e);
        end
      end
    end
  end

  // Push allocation: free space is taken from the start-of-cycle count only.
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] cnt_q, cnt_d, free, n_push, n_drop;
  logic [NSRC-1:0]   push_en;
  logic [PTR_W-1:0]  push_slot [NSRC];
  logic              pop;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    free   = CNT_FW'(FIFO_DEPTH) - cnt_q;
    n_push = '0;
    n_drop = '0;
    for (int s = 0; s < NSRC; s++) begin
      push_en[s]   = 1'b0;
      push_slot[s] = wr_ptr_q + n_push[PTR_W-1:0];
      if (hit[s]) begin
        if (n_push < free) begin
          push_en[s] = 1'b1;
          n_push     = n_push + CNT_FW'(1);
        end else begin
          n_drop = n_drop + CNT_FW'(1);
        end
      end
    end

    pop      = evt_valid & evt_ready;
    cnt_d    = cnt_q + n_push - CNT_FW'(pop);
    wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (n_drop != '0) begin
      // A drop in the same cycle as a clear wins: restart from this cycle's drops.
      drop_cnt_d = ovf_clr ? CNT_W'(n_drop) : (drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0]);
      ovf_d      = 1'b1;
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      fire_q <= '0;
      for (int s = 0; s < NSRC; s++) addr_q[s] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      fire_q <= fire_d;
      for (int s = 0; s < NSRC; s++) addr_q[s] <= addr_d[s];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: nothing is visible unless the count says so.
  evt_t mem_q [FIFO_DEPTH];

  always_ff @(posedge afu_clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push_en[s]) mem_q[push_slot[s]] <= ent[s];
    end
  end

  evt_t head;

  always_comb begin
    evt_valid  = (cnt_q != '0);
    head       = evt_valid ? mem_q[rd_ptr_q] : '0;
    evt_idx    = head.idx;
    evt_pg_off = head.off;
    evt_is_wr  = head.wr;
    evt_ch     = head.ch;
    fifo_cnt   = cnt_q;
    drop_cnt   = drop_cnt_q;
    ovf_sticky = ovf_q;
  end

endmodule

// File: tb/tb_iafu_snooper_q.sv
// Scoreboard bench for iafu_snooper_q: directed stimulus pushes hand-computed events,
// a negedge monitor pops and compares on every accepted event.
module tb_iafu_snooper_q;

  logic              afu_clk = 1'b0;
  logic              afu_rst;
  logic              snp_en;
  logic [1:0]        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [127:0]      ar_addr, aw_addr;
  logic [7:0][63:0]  snp_page_addr;
  logic [7:0]        snp_page_vld;
  logic              evt_valid, evt_ready, evt_is_wr, ovf_sticky, ovf_clr;
  logic [2:0]        evt_idx;
  logic [5:0]        evt_pg_off;
  logic [0:0]        evt_ch;
  logic [4:0]        fifo_cnt;
  logic [15:0]       drop_cnt;

  typedef struct packed {
    logic [2:0] idx;
    logic [5:0] off;
    logic       wr;
    logic       ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  iafu_snooper_q dut (
    .afu_clk       (afu_clk),
    .afu_rst       (afu_rst),
    .snp_en        (snp_en),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar_addr       (ar_addr),
    .aw_valid      (aw_valid),
    .aw_ready      (aw_ready),
    .aw_addr       (aw_addr),
    .snp_page_addr (snp_page_addr),
    .snp_page_vld  (snp_page_vld),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_idx       (evt_idx),
    .evt_pg_off    (evt_pg_off),
    .evt_is_wr     (evt_is_wr),
    .evt_ch        (evt_ch),
    .fifo_cnt      (fifo_cnt),
    .drop_cnt      (drop_cnt),
    .ovf_sticky    (ovf_sticky),
    .ovf_clr       (ovf_clr)
  );

  always #5 afu_clk = ~afu_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] page(input int e, input int off);
    return 64'h0000_1234_2000 + (64'(e) << 12) + (64'(off) << 6);
  endfunction

  task automatic push_exp(input int idx, input int off, input bit wr, input bit ch);
    exp_t e;
    e.idx = 3'(idx);
    e.off = 6'(off);
    e.wr  = wr;
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  // Source order: [0]=ch0 AR, [1]=ch0 AW, [2]=ch1 AR, [3]=ch1 AW. Holds for one cycle.
  task automatic fire(input logic [3:0] v, input logic [3:0] r, input logic [63:0] a0,
                      input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3);
    ar_valid = {v[2], v[0]};
    aw_valid = {v[3], v[1]};
    ar_ready = {r[2], r[0]};
    aw_ready = {r[3], r[1]};
    ar_addr  = {a2, a0};
    aw_addr  = {a3, a1};
    @(posedge afu_clk);
    #1;
    ar_valid = '0;
    aw_valid = '0;
    ar_ready = '0;
    aw_ready = '0;
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge afu_clk);
    repeat (2) @(posedge afu_clk);
    #1;
    @(negedge afu_clk);
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_cnt"}, 64'(fifo_cnt), 64'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge afu_clk) begin
    if (!afu_rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_evt: got %0h expected none",
                 {evt_idx, evt_pg_off, evt_is_wr, evt_ch});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_fields", 64'({evt_idx, evt_pg_off, evt_is_wr, evt_ch}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    afu_rst   = 1'b1;
    snp_en    = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    ar_valid  = '0;
    aw_valid  = '0;
    ar_ready  = '0;
    aw_ready  = '0;
    ar_addr   = '0;
    aw_addr   = '0;
    for (int e = 0; e < 8; e++) snp_page_addr[e] = page(e, 0);
    snp_page_vld = 8'h7F;

    @(negedge afu_clk);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    chk("rst_fields", 64'({evt_idx, evt_pg_off, evt_is_wr, evt_ch}), 64'd0);
    @(posedge afu_clk);
    #1;
    afu_rst = 1'b0;

    // Single hit, two-cycle latency.
    push_exp(3, 'h3F, 1'b0, 1'b0);
    fire(4'b0001, 4'b0001, 64'h0000_1234_5FC0, 64'd0, 64'd0, 64'd0);
    @(negedge afu_clk);
    chk("single_n1_valid", 64'(evt_valid), 64'd0);
    @(negedge afu_clk);
    chk("single_n2_valid", 64'(evt_valid), 64'd1);
    drain("single");

    // Four simultaneous hits.
    evt_ready = 1'b0;
    push_exp(1, 'h01, 1'b0, 1'b0);
    push_exp(2, 'h02, 1'b1, 1'b0);
    push_exp(5, 'h10, 1'b0, 1'b1);
    push_exp(6, 'h2A, 1'b1, 1'b1);
    fire(4'hF, 4'hF, page(1, 'h01), page(2, 'h02), page(5, 'h10), page(6, 'h2A));
    @(negedge afu_clk);
    @(negedge afu_clk);
    chk("multi_cnt", 64'(fifo_cnt), 64'd4);
    drain("multi");

    // Duplicate entry: lowest index wins.
    snp_page_addr[1] = page(5, 0);
    push_exp(1, 'h11, 1'b0, 1'b1);
    fire(4'b0100, 4'b0100, 64'd0, 64'd0, page(5, 'h11), 64'd0);
    drain("dup");
    snp_page_addr[1] = page(1, 0);

    // Misses and gating.
    fire(4'b0001, 4'b0001, page(7, 'h04), 64'd0, 64'd0, 64'd0);
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("miss_invalid_entry", 64'({evt_valid, fifo_cnt}), 64'd0);
    fire(4'b0010, 4'b0000, 64'd0, page(3, 0), 64'd0, 64'd0);
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("miss_no_ready", 64'({evt_valid, fifo_cnt}), 64'd0);
    @(posedge afu_clk);
    #1;
    snp_en = 1'b0;
    fire(4'b0100, 4'b0100, 64'd0, 64'd0, page(3, 1), 64'd0);
    snp_en = 1'b1;
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("miss_snp_off", 64'({evt_valid, fifo_cnt}), 64'd0);
    @(posedge afu_clk);
    #1;

    // Backpressure: 18 hits into 16 slots; k-th hit uses entry (k+3)%7, offset k+8.
    evt_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      logic [63:0] a [4];
      for (int s = 0; s < 4; s++) begin
        int k;
        k = c * 4 + s;
        a[s] = page((k + 3) % 7, k + 8);
        if (k < 16) push_exp((k + 3) % 7, k + 8, s[0], s[1]);
      end
      if (c < 4) fire(4'hF, 4'hF, a[0], a[1], a[2], a[3]);
      else       fire(4'b0011, 4'b0011, a[0], a[1], 64'd0, 64'd0);
    end
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("bp_cnt", 64'(fifo_cnt), 64'd16);
    chk("bp_drop", 64'(drop_cnt), 64'd2);
    chk("bp_ovf", 64'(ovf_sticky), 64'd1);
    chk("bp_head", 64'({evt_idx, evt_pg_off, evt_is_wr, evt_ch}), 64'({3'd3, 6'd8, 2'b00}));
    @(negedge afu_clk);
    chk("bp_head_hold", 64'({evt_valid, evt_idx, evt_pg_off, evt_is_wr, evt_ch}),
        64'({1'b1, 3'd3, 6'd8, 2'b00}));
    @(posedge afu_clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge afu_clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge afu_clk);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(ovf_sticky), 64'd0);
    @(posedge afu_clk);
    #1;

    // Full FIFO, two hits plus a pop in the same cycle: pop frees no push room.
    fire(4'b0011, 4'b0011, page(0, 1), page(1, 2), 64'd0, 64'd0);
    evt_ready = 1'b1;
    @(posedge afu_clk);
    #1;
    evt_ready = 1'b0;
    @(negedge afu_clk);
    chk("fullpop_cnt", 64'(fifo_cnt), 64'd15);
    chk("fullpop_drop", 64'(drop_cnt), 64'd2);
    chk("fullpop_ovf", 64'(ovf_sticky), 64'd1);
    drain("fullpop");

    // Reset mid-stream with five queued events.
    evt_ready = 1'b0;
    @(posedge afu_clk);
    #1;
    fire(4'hF, 4'hF, page(0, 1), page(1, 1), page(2, 1), page(3, 1));
    fire(4'b0001, 4'b0001, page(4, 1), 64'd0, 64'd0, 64'd0);
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("prerst_cnt", 64'(fifo_cnt), 64'd5);
    #1;
    afu_rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(evt_valid), 64'd0);
    chk("midrst_cnt", 64'(fifo_cnt), 64'd0);
    chk("midrst_drop", 64'({drop_cnt, ovf_sticky}), 64'd0);
    @(posedge afu_clk);
    #1;
    afu_rst   = 1'b0;
    evt_ready = 1'b1;
    @(posedge afu_clk);
    #1;
    push_exp(4, 5, 1'b1, 1'b1);
    fire(4'b1000, 4'b1000, 64'd0, 64'd0, 64'd0, page(4, 5));
    @(negedge afu_clk);
    chk("postrst_n1_valid", 64'(evt_valid), 64'd0);
    @(negedge afu_clk);
    chk("postrst_n2_valid", 64'(evt_valid), 64'd1);
    drain("postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/iafu_snooper_q.md
Name: iafu_snooper_q

Overview:
- Parametrised successor to the two-channel page snooper.
- Monitors AR and AW address handshakes on NUM_CH memory-controller AXI channels and matches each accepted address against a GRP_SIZE-entry table of migrating pages.
- Every hit becomes one event in an internal multi-push FIFO, so simultaneous hits are not lost; a drop counter and sticky overflow flag cover FIFO exhaustion.
- Sits between the CXL IP / MC AXI boundary and the migration engine, which drains events through a valid/ready port.

Parameters:
- NUM_CH, 2, number of MC AXI channels snooped.
- GRP_SIZE, 8, migration group size; number of page-table entries.
- PG_SHIFT, 12, log2 page size; page-number field is addr[51:PG_SHIFT].
- LINE_SHIFT, 6, log2 line size; page offset is addr[PG_SHIFT-1:LINE_SHIFT].
- FIFO_DEPTH, 16, event FIFO entries; power of two, must be >= 2*NUM_CH.
- CNT_W, 16, drop counter width.

Ports:
- afu_clk  in  1  clock.
- afu_rst  in  1  asynchronous, active-high reset.
- snp_en  in  1  snoop enable; when low, no new handshakes are captured.
- ar_valid  in  NUM_CH  per-channel arvalid.
- ar_ready  in  NUM_CH  per-channel arready.
- ar_addr  in  NUM_CH*64  per-channel araddr; channel c is bits [64c+63:64c].
- aw_valid  in  NUM_CH  per-channel awvalid.
- aw_ready  in  NUM_CH  per-channel awready.
- aw_addr  in  NUM_CH*64  per-channel awaddr; same packing as ar_addr.
- snp_page_addr  in  GRP_SIZE x 64  page-table addresses.
- snp_page_vld  in  GRP_SIZE  per-entry valid; invalid entries never match.
- evt_valid  out  1  head event available.
- evt_ready  in  1  consumer accepts head event.
- evt_idx  out  clog2(GRP_SIZE)  matching table index.
- evt_pg_off  out  PG_SHIFT-LINE_SHIFT  line offset within the page.
- evt_is_wr  out  1  1 = AW hit, 0 = AR hit.
- evt_ch  out  max(1,clog2(NUM_CH))  channel number.
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  dropped-event count; saturates at all-ones.
- ovf_sticky  out  1  set on any drop.
- ovf_clr  in  1  clears drop_cnt and ovf_sticky.

Behaviour:
- Reset (async assert, sync deassert via afu_clk):
  - Stage-1 registers, FIFO pointers, fifo_cnt, drop_cnt and ovf_sticky clear to 0.
  - evt_valid = 0; evt_idx, evt_pg_off, evt_is_wr and evt_ch read 0.
  - Reset mid-operation discards all in-flight and queued events.
- Sources: there are 2*NUM_CH sources in fixed priority order ch0 AR, ch0 AW, ch1 AR, ch1 AW, and so on.
- Stage 1 (cycle N):
  - fire = valid & ready & snp_en.
  - Each fire and its address are registered at the edge ending cycle N.
- Stage 2 (cycle N+1):
  - Registered page number is compared with every entry where snp_page_vld=1, using addr[51:PG_SHIFT].
  - The lowest matching index wins. Duplicate table entries therefore resolve deterministically.
  - Table contents are sampled in cycle N+1, not N.
  - A source with fire and a match is a hit.
- Push:
  - All hits of cycle N+1 are written at the closing edge, in source order, to consecutive FIFO slots.
  - Write pointer advances by the number pushed.
- Latency: a hit into an empty FIFO gives evt_valid=1 in cycle N+2. Output fields come from the FIFO head, not a registered copy.
- Pop:
  - evt_valid = (fifo_cnt != 0).
  - Pop occurs when evt_valid & evt_ready. Head fields hold stable while evt_valid & !evt_ready.
- Capacity:
  - free = FIFO_DEPTH - fifo_cnt at start of cycle. A same-cycle pop does not create push room.
  - If hits > free, the first `free` hits in source order are pushed and the remainder dropped.
  - drop_cnt += dropped (saturating); ovf_sticky set.
  - fifo_cnt_next = fifo_cnt + pushed - popped.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous ovf_clr and drop: the counter loads the new drop amount and the sticky flag stays set. Drops win over the clear.
- snp_en deassert: events already in stage 1 or the FIFO still complete.

Test Plan:
- Single hit: table[3]=0x0000_1234_5000 vld; ch0 AR fire addr 0x0000_1234_5FC0 in cycle N -> evt_valid in N+2 with idx=3, pg_off=0x3F, is_wr=0, ch=0.
- Simultaneous hits, NUM_CH=2: all four sources fire on table entries 1,2,5,6 in one cycle -> four events popped in order (ch0 AR, ch0 AW, ch1 AR, ch1 AW), fifo_cnt peaks at 4.
- Miss and gating:
  - Address matching only an entry with vld=0 -> no event.
  - Valid without ready -> no event.
  - Hit while snp_en=0 -> no event.
- Backpressure and overflow:
  - Hold evt_ready=0; generate 18 hits with FIFO_DEPTH=16 -> fifo_cnt=16, drop_cnt=2, ovf_sticky=1, and the head holds stable.
  - Pulse ovf_clr -> drop_cnt=0 and ovf_sticky=0.
- Full FIFO with 2 hits and a pop in the same cycle -> both hits dropped, fifo_cnt=15, drop_cnt+=2.
- Reset mid-stream:
  - Assert afu_rst asynchronously with 5 queued events -> evt_valid=0 and fifo_cnt=0 immediately.
  - After release, the next hit appears 2 cycles after its handshake.
